// File: rtl/tile_pkg.sv
// tile_pkg: state encoding and address helpers shared by the tile blitter files
package tile_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, EMIT, ADVANCE, DONE} state_t;
    // Counter width for a dimension of n pixels (COL_W = cnt_w(TILE_W), ROW_W = cnt_w(TILE_H))
    function automatic int cnt_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    // Byte offset of byte b of pixel (row, col) within a row-major packed tile
    function automatic int unsigned pix_byte_offset(int unsigned row, int unsigned col, int unsigned b,
                                                    int unsigned tile_w, int unsigned bpp);
        return (row * tile_w + col) * bpp + b;
    endfunction
endpackage

// File: rtl/tile_byte_fetcher.sv
// tile_byte_fetcher: registers a ROM byte address and times out the ROM read latency
//   clk, resetn     clock, async active-low reset
//   req, addr       load addr onto rom_addr and start the latency wait
//   rom_addr        registered ROM address
//   fetch_done      high in the last wait cycle; rom_data is valid in the following cycle
module tile_byte_fetcher
    import tile_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int ROM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              fetch_done
);
    logic [1:0] cnt;
    logic       pending;

    assign fetch_done = pending && cnt == 2'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rom_addr <= '0;
            cnt      <= '0;
            pending  <= 1'b0;
        end else if (req) begin
            rom_addr <= addr;
            cnt      <= 2'(ROM_LATENCY - 1);
            pending  <= 1'b1;
        end else if (pending) begin
            cnt     <= cnt == 2'd0 ? cnt : cnt - 2'd1;
            pending <= cnt != 2'd0;
        end
    end
endmodule

// File: rtl/tile_blitter.sv
// tile_blitter: copies one TILE_W x TILE_H tile from byte ROM into a valid/ready pixel stream
//   clk, resetn                          clock, async active-low reset
//   start, tile_base, x_origin, y_origin,
//   flip_x, flip_y                       blit request, sampled in IDLE only
//   busy, done                           blit in progress / one-cycle completion pulse
//   rom_addr, rom_data                   tile ROM byte port (ROM_LATENCY cycles)
//   pix_valid, pix_ready                 pixel beat handshake
//   pix_x, pix_y, pix_rgb                destination coordinate and colour of the beat
module tile_blitter
    import tile_pkg::*;
#(
    parameter int          TILE_W      = 8,
    parameter int          TILE_H      = 8,
    parameter int          COORD_W     = 8,
    parameter int          ADDR_W      = 12,
    parameter int          BPP         = 3,
    parameter int          ROM_LATENCY = 1,
    parameter int          KEY_EN      = 1,
    parameter logic [23:0] KEY_RGB     = 24'hFF00FF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [ADDR_W-1:0]  tile_base,
    input  logic [COORD_W-1:0] x_origin,
    input  logic [COORD_W-1:0] y_origin,
    input  logic               flip_x,
    input  logic               flip_y,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [7:0]         rom_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [23:0]        pix_rgb
);
    localparam int COL_W = cnt_w(TILE_W);
    localparam int ROW_W = cnt_w(TILE_H);
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(TILE_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(TILE_H - 1);
    localparam logic [1:0]       BYTE_MAX = 2'(BPP - 1);

    state_t             state, state_n;
    logic [COL_W-1:0]   col, col_n;
    logic [ROW_W-1:0]   row, row_n;
    logic [1:0]         byte_idx, byte_n;
    logic [ADDR_W-1:0]  base_l, base_n, fetch_addr;
    logic [COORD_W-1:0] x_l, y_l;
    logic               flip_x_l, flip_y_l;
    logic [15:0]        acc;
    logic [23:0]        acc_n;
    logic               fetch_req, fetch_done, key_hit, last_byte;

    // Bytes arrive MSB first; acc is cleared per pixel so BPP<3 colours come out zero-extended
    assign acc_n      = {acc, rom_data};
    assign key_hit    = KEY_EN != 0 && acc_n == KEY_RGB;
    assign last_byte  = byte_idx == BYTE_MAX;
    assign busy       = state != IDLE && state != DONE;
    assign done       = state == DONE;
    // The address is issued on the edge entering FETCH so FETCH lasts exactly ROM_LATENCY cycles
    assign fetch_req  = state_n == FETCH && state != FETCH;
    assign fetch_addr = base_n + ADDR_W'(pix_byte_offset(32'(row_n), 32'(col_n), 32'(byte_n), TILE_W, BPP));

    tile_byte_fetcher #(.ADDR_W(ADDR_W), .ROM_LATENCY(ROM_LATENCY)) u_fetch (
        .clk(clk),
        .resetn(resetn),
        .req(fetch_req),
        .addr(fetch_addr),
        .rom_addr(rom_addr),
        .fetch_done(fetch_done)
    );

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        byte_n  = byte_idx;
        base_n  = base_l;
        case (state)
            IDLE: if (start) begin
                state_n = FETCH;
                col_n   = '0;
                row_n   = '0;
                byte_n  = '0;
                base_n  = tile_base;
            end
            FETCH:   state_n = fetch_done ? CAPTURE : FETCH;
            CAPTURE: begin
                state_n = last_byte ? EMIT : FETCH;
                byte_n  = last_byte ? byte_idx : byte_idx + 2'd1;
            end
            // pix_valid low here means the pixel was keyed out
            EMIT:    state_n = (!pix_valid || pix_ready) ? ADVANCE : EMIT;
            ADVANCE: begin
                byte_n  = '0;
                col_n   = col == COL_MAX ? '0 : col + 1'b1;
                row_n   = col == COL_MAX ? row + 1'b1 : row;
                state_n = (col == COL_MAX && row == ROW_MAX) ? DONE : FETCH;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            byte_idx  <= '0;
            base_l    <= '0;
            x_l       <= '0;
            y_l       <= '0;
            flip_x_l  <= 1'b0;
            flip_y_l  <= 1'b0;
            acc       <= '0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
        end else begin
            state    <= state_n;
            col      <= col_n;
            row      <= row_n;
            byte_idx <= byte_n;
            base_l   <= base_n;
            if (state == IDLE && start) begin
                x_l      <= x_origin;
                y_l      <= y_origin;
                flip_x_l <= flip_x;
                flip_y_l <= flip_y;
            end
            if (state == CAPTURE)
                acc <= acc_n[15:0];
            else if (state == ADVANCE || state == IDLE)
                acc <= '0;
            if (state == CAPTURE && last_byte) begin
                pix_valid <= !key_hit;
                pix_x     <= x_l + (flip_x_l ? COORD_W'(COL_MAX - col) : COORD_W'(col));
                pix_y     <= y_l + (flip_y_l ? COORD_W'(ROW_MAX - row) : COORD_W'(row));
                pix_rgb   <= acc_n;
            end else if (pix_valid && pix_ready)
                pix_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tile_blitter.sv
// tb_tile_blitter: randomized self-checking bench for tile_blitter against a raster-order beat model
module tb_tile_blitter;
    localparam int          TW  = 8;
    localparam int          TH  = 8;
    localparam int          CW  = 8;
    localparam int          AW  = 12;
    localparam int          BPP = 3;
    localparam int          LAT = 1;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] tile_base = '0;
    logic [CW-1:0] x_origin = '0;
    logic [CW-1:0] y_origin = '0;
    logic          flip_x = 1'b0;
    logic          flip_y = 1'b0;
    logic          pix_ready = 1'b1;
    logic          busy, done, pix_valid;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic [CW-1:0] pix_x, pix_y;
    logic [23:0]   pix_rgb;

    logic [7:0]    rom [0:(1<<AW)-1];
    logic [39:0]   exp_q[$];
    int            passed = 0;
    int            total = 0;
    int            beats = 0;
    int            done_cnt = 0;
    int            busy_cyc = 0;
    logic [39:0]   first_beat = '0;
    logic [39:0]   last_beat = '0;
    logic [39:0]   stall_val = '0;
    logic [39:0]   cur;
    bit            stall_prev = 1'b0;
    bit            rnd_ready = 1'b0;

    tile_blitter #(.TILE_W(TW), .TILE_H(TH), .COORD_W(CW), .ADDR_W(AW), .BPP(BPP),
                   .ROM_LATENCY(LAT), .KEY_EN(1), .KEY_RGB(KEY)) dut (
        .clk(clk), .resetn(resetn), .start(start), .tile_base(tile_base),
        .x_origin(x_origin), .y_origin(y_origin), .flip_x(flip_x), .flip_y(flip_y),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    initial forever begin
        @(posedge clk);
        #1;
        pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Every pixel in source raster order, placed at origin + (mirrored) offset mod 2^CW, keyed pixels dropped
    function automatic int build_exp(input logic [AW-1:0] base, input logic [CW-1:0] x0,
                                     input logic [CW-1:0] y0, input logic fx, input logic fy);
        logic [23:0] rgb;
        exp_q.delete();
        for (int r = 0; r < TH; r++)
            for (int c = 0; c < TW; c++) begin
                rgb = '0;
                for (int b = 0; b < BPP; b++)
                    rgb = (rgb << 8) | 24'(rom[AW'(int'(base) + (r * TW + c) * BPP + b)]);
                if (rgb != KEY)
                    exp_q.push_back({CW'(int'(x0) + (fx ? TW - 1 - c : c)),
                                     CW'(int'(y0) + (fy ? TH - 1 - r : r)), rgb});
            end
        return exp_q.size();
    endfunction

    always @(negedge clk) begin
        cur = {pix_x, pix_y, pix_rgb};
        if (!resetn) stall_prev = 1'b0;
        else begin
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (stall_prev) check("stall_hold", {pix_valid, cur}, {1'b1, stall_val});
            if (pix_valid && pix_ready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("beat", cur, exp_q.pop_front());
                if (beats == 0) first_beat = cur;
                last_beat = cur;
                beats++;
            end
            stall_prev = pix_valid && !pix_ready;
            stall_val  = cur;
        end
    end

    task automatic kick(input logic [AW-1:0] base, input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                        input logic fx, input logic fy, input bit rnd);
        rnd_ready = rnd;
        beats = 0;
        done_cnt = 0;
        busy_cyc = 0;
        @(negedge clk);
        tile_base = base; x_origin = x0; y_origin = y0; flip_x = fx; flip_y = fy; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tile_base = AW'($urandom); x_origin = CW'($urandom); y_origin = CW'($urandom);
        flip_x = 1'($urandom); flip_y = 1'($urandom);
    endtask

    task automatic run_blit(input logic [AW-1:0] base, input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                            input logic fx, input logic fy, input bit rnd, input bit poke);
        int n;
        bit got_done;
        n = build_exp(base, x0, y0, fx, fy);
        kick(base, x0, y0, fx, fy, rnd);
        got_done = 1'b0;
        for (int i = 0; i < 20000 && !got_done; i++) begin
            @(negedge clk);
            start = poke && i == 100;
            if (done) got_done = 1'b1;
        end
        check("done_seen", got_done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", busy, 0);
        check("beat_count", beats, n);
        check("queue_empty", exp_q.size(), 0);
        check("done_pulses", done_cnt, 1);
        if (!rnd) check("busy_cycles", busy_cyc, TW * TH * (BPP * (LAT + 1) + 2));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = 8'(i);
        repeat (3) @(negedge clk);
        check("reset_state", {busy, done, pix_valid, rom_addr, pix_x, pix_y, pix_rgb}, 0);
        resetn = 1'b1;
        @(negedge clk);

        run_blit(0, 10, 20, 0, 0, 0, 0);
        check("plain_first", first_beat, {8'd10, 8'd20, 24'h000102});
        check("plain_last", last_beat, {8'd17, 8'd27, 24'hBDBEBF});

        run_blit(0, 0, 0, 1, 1, 0, 0);
        check("flip_first", first_beat, {8'd7, 8'd7, 24'h000102});
        check("flip_last", last_beat, {8'd0, 8'd0, 24'hBDBEBF});

        rom[15] = 8'hFF; rom[16] = 8'h00; rom[17] = 8'hFF;
        run_blit(0, 10, 20, 0, 0, 0, 0);
        check("key_beats", beats, TW * TH - 1);
        rom[15] = 8'd15; rom[16] = 8'd16; rom[17] = 8'd17;

        run_blit(0, 10, 20, 0, 0, 1, 1);

        run_blit(0, 252, 0, 0, 0, 0, 0);
        check("wrap_first_x", first_beat[39:32], 252);
        check("wrap_last_x", last_beat[39:32], 3);

        void'(build_exp(0, 10, 20, 0, 0));
        kick(0, 10, 20, 0, 0, 0);
        for (int i = 0; i < 2000 && beats < 30; i++) @(negedge clk);
        check("reached_beat30", beats >= 30, 1);
        resetn = 1'b0;
        #1;
        check("abort_outputs", {busy, done, pix_valid, rom_addr, pix_x, pix_y, pix_rgb}, 0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        beats = 0;
        repeat (20) @(negedge clk);
        check("abort_idle", {32'(beats), 31'd0, busy}, 0);
        run_blit(0, 10, 20, 0, 0, 0, 0);
        check("restart_first", first_beat, {8'd10, 8'd20, 24'h000102});

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < (1 << AW); i++) rom[i] = 8'($urandom);
            for (int k = 0; k < 4; k++) begin
                int p;
                p = $urandom_range(0, (1 << AW) - 3);
                rom[p] = 8'hFF; rom[p + 1] = 8'h00; rom[p + 2] = 8'hFF;
            end
            run_blit(AW'($urandom), CW'($urandom), CW'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tile_blitter.md
Name: tile_blitter

Overview:
- Parametrised successor to the single-size tile drawer.
- Copies one TILE_W x TILE_H tile of packed RGB bytes from tile ROM into the VGA pixel stream at a given screen origin.
- Generalised in tile size, coordinate width, ROM read latency and bytes per pixel.
- Adds X/Y mirroring, colour-key transparency, and a valid/ready pixel output in place of a fire-and-forget draw strobe.
- Sits between the game-logic sequencer (start/busy/done) and the VGA framebuffer writer.

Parameters:
- TILE_W, 8, tile width in pixels (power of two, 2..64)
- TILE_H, 8, tile height in pixels (power of two, 2..64)
- COORD_W, 8, screen coordinate width
- ADDR_W, 12, ROM byte-address width
- BPP, 3, bytes per pixel (1..3); the first byte fetched is the MSB of the colour
- ROM_LATENCY, 1, cycles from address presented to data valid (1..4)
- KEY_EN, 1, enables colour-key transparency
- KEY_RGB, 24'hFF00FF, transparent colour, compared against the assembled pixel

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  begin a blit; sampled only in IDLE
- tile_base  in  ADDR_W  ROM byte address of pixel (0,0)
- x_origin  in  COORD_W  screen x of tile's top-left corner
- y_origin  in  COORD_W  screen y of tile's top-left corner
- flip_x  in  1  mirror the tile horizontally
- flip_y  in  1  mirror the tile vertically
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the blit completes
- rom_addr  out  ADDR_W  ROM byte address (registered)
- rom_data  in  8  ROM read data
- pix_valid  out  1  pixel beat valid
- pix_ready  in  1  framebuffer writer accepts the beat
- pix_x  out  COORD_W  destination x
- pix_y  out  COORD_W  destination y
- pix_rgb  out  24  colour, zero-extended when BPP<3

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, pix_valid=0; rom_addr, pix_x, pix_y, pix_rgb=0; counters=0. Reset mid-blit aborts immediately and emits no further beats.
- IDLE: when start=1, latch tile_base, x_origin, y_origin, flip_x and flip_y; clear col, row and byte counters; go to FETCH. Inputs may change after acceptance.
- start while busy is ignored, with no queuing.
- FETCH: rom_addr <= base_l + (row*TILE_W + col)*BPP + byte_idx. Hold for ROM_LATENCY cycles, then go to CAPTURE.
- CAPTURE: shift rom_data into the colour accumulator.
  - If byte_idx < BPP-1: increment byte_idx and return to FETCH.
  - Otherwise go to EMIT.
- Each pixel therefore costs BPP*(ROM_LATENCY+1) fetch cycles. Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W.
- EMIT, colour equals KEY_RGB and KEY_EN=1: assert no beat, go to ADVANCE.
- EMIT, otherwise: assert pix_valid with registered pix_x, pix_y and pix_rgb.
  - These outputs hold stable while pix_valid=1 and pix_ready=0.
  - On pix_valid and pix_ready, drop pix_valid next cycle and go to ADVANCE.
  - pix_ready may be high before pix_valid; a beat completes in the first EMIT cycle if so.
- Destination coordinates:
  - pix_x = x_l + (flip_x ? TILE_W-1-col : col)
  - pix_y = y_l + (flip_y ? TILE_H-1-row : row)
  - Both are computed modulo 2^COORD_W (wrap at screen edge, no clipping).
- ADVANCE: clear byte_idx, then:
  - If col < TILE_W-1: col++, go to FETCH.
  - Else if row < TILE_H-1: col=0, row++, go to FETCH.
  - Else go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, go to IDLE.
- A start arriving in the DONE cycle is ignored.
- Scan order is source raster order (row-major) regardless of flip.
- Outputs are never tri-stated; bus sharing is handled by the external arbiter using busy.

Decomposition:
- Package tile_pkg holds:
  - the state enum: IDLE, FETCH, CAPTURE, EMIT, ADVANCE, DONE
  - COL_W = $clog2(TILE_W), ROW_W = $clog2(TILE_H)
  - a function computing the pixel byte offset
- One sub-module, tile_byte_fetcher: takes an address and a request, and returns a data-valid pulse after ROM_LATENCY cycles using a wait counter. It isolates the ROM timing from the pixel FSM.

Test Plan:
- Default params; ROM[i]=i; start with base=0, origin (10,20), no flip, pix_ready=1 → 64 beats; beat 0 is (10,20,24'h000102); beat 63 is (17,27,24'hBDBEBF); done once; busy high for exactly the blit duration.
- flip_x=1, flip_y=1, origin (0,0), same ROM → first beat at (7,7) with colour 24'h000102; last beat at (0,0).
- pixel 5 bytes set to FF,00,FF with KEY_EN=1 → 63 beats, none at the pixel-5 coordinate; done still asserts.
- pix_ready toggled 0/1 pseudo-randomly → no beat lost or duplicated; outputs are stable during stalls; the beat sequence matches the ready=1 run.
- origin (252,0) with COORD_W=8 → x wraps to 252..255, 0..3.
- resetn pulsed low at beat 30; start re-issued → first beat restarts at pixel 0; start pulsed mid-blit → ignored.
